calc_mode_controller: RTL and testbench

Clocked mode sequencer for the DE10-Lite calculator top level. Converts the two debounced push-button levels into a wrapped 0..NUM_MODES-1 mode index. Launches and tracks the multi-cycle serial operators (full shifter, full arithmetical shifter, full rotator) through a start/done handshake with timeout. Tells the display path when the selected result is valid.

---
 rtl/calc_mode_if.sv | 24 ++
 rtl/calc_mode_controller.sv | 142 ++++++++++++++
 tb/tb_calc_mode_controller.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/calc_mode_if.sv
// Button/switch inputs, serial-operator handshake and status outputs of the calculator mode controller.
interface calc_mode_if #(
  parameter int MODE_W = 4
);
  logic              inc_btn;
  logic              dec_btn;
  logic [9:0]        sw;
  logic              op_done;
  logic [MODE_W-1:0] mode;
  logic              op_start;
  logic              busy;
  logic              result_valid;
  logic              timeout_err;

  modport master (
    output inc_btn, dec_btn, sw, op_done,
    input  mode, op_start, busy, result_valid, timeout_err
  );

  modport slave (
    input  inc_btn, dec_btn, sw, op_done,
    output mode, op_start, busy, result_valid, timeout_err
  );
endinterface

// File: rtl/calc_mode_controller.sv
// Mode sequencer: button edges step a wrapped mode index and launch serial operators with done/timeout tracking.
//   state    | meaning
//   S_SETTLE | combinational mode selected, result not yet valid for one cycle
//   S_IDLE   | result stable (or timed out), waiting for a request
//   S_ISSUE  | op_start pulse to the serial operator
//   S_WAIT   | waiting for op_done, counting toward timeout
module calc_mode_controller #(
  parameter int                   NUM_MODES   = 12,
  parameter int                   MODE_W      = 4,
  parameter logic [NUM_MODES-1:0] SERIAL_MASK = 12'h150,
  parameter int                   TIMEOUT     = 255
) (
  input logic        clk,
  input logic        rst,
  calc_mode_if.slave bus
);

  localparam logic [1:0] S_SETTLE = 2'd0;
  localparam logic [1:0] S_IDLE   = 2'd1;
  localparam logic [1:0] S_ISSUE  = 2'd2;
  localparam logic [1:0] S_WAIT   = 2'd3;

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [MODE_W-1:0] MODE_MAX = MODE_W'(NUM_MODES - 1);

  logic       r_inc_s1, r_inc_s2, r_inc_d;
  logic       r_dec_s1, r_dec_s2, r_dec_d;
  logic [9:0] r_sw_s1, r_sw_s2, r_sw_d;

  logic [1:0]        r_state;
  logic [MODE_W-1:0] r_mode;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_op_start;
  logic              r_busy;
  logic              r_result_valid;
  logic              r_timeout_err;

  logic              w_inc_rise, w_dec_rise, w_sw_chg, w_req, w_serial;
  logic [MODE_W-1:0] w_mode_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inc_s1 <= 1'b0;
      r_inc_s2 <= 1'b0;
      r_inc_d  <= 1'b0;
      r_dec_s1 <= 1'b0;
      r_dec_s2 <= 1'b0;
      r_dec_d  <= 1'b0;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_sw_d   <= '0;
    end else begin
      r_inc_s1 <= bus.inc_btn;
      r_inc_s2 <= r_inc_s1;
      r_inc_d  <= r_inc_s2;
      r_dec_s1 <= bus.dec_btn;
      r_dec_s2 <= r_dec_s1;
      r_dec_d  <= r_dec_s2;
      r_sw_s1  <= bus.sw;
      r_sw_s2  <= r_sw_s1;
      r_sw_d   <= r_sw_s2;
    end
  end

  assign w_inc_rise = r_inc_s2 & ~r_inc_d;
  assign w_dec_rise = r_dec_s2 & ~r_dec_d;
  assign w_sw_chg   = |(r_sw_s2 ^ r_sw_d);
  // Simultaneous inc and dec edges cancel: no step and no request.
  assign w_req      = (w_inc_rise ^ w_dec_rise) | w_sw_chg;

  always_comb begin
    w_mode_next = r_mode;
    if (w_inc_rise && !w_dec_rise)
      w_mode_next = (r_mode == MODE_MAX) ? '0 : r_mode + 1'b1;
    else if (w_dec_rise && !w_inc_rise)
      w_mode_next = (r_mode == '0) ? MODE_MAX : r_mode - 1'b1;
  end

  assign w_serial = SERIAL_MASK[w_mode_next];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_SETTLE;
      r_mode         <= '0;
      r_cnt          <= '0;
      r_op_start     <= 1'b0;
      r_busy         <= 1'b1;
      r_result_valid <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_op_start <= 1'b0;
      if (w_req) begin
        // A new request abandons any in-flight operation.
        r_mode         <= w_mode_next;
        r_cnt          <= '0;
        r_busy         <= 1'b1;
        r_result_valid <= 1'b0;
        r_timeout_err  <= 1'b0;
        if (w_serial) begin
          r_state    <= S_ISSUE;
          r_op_start <= 1'b1;
        end else begin
          r_state <= S_SETTLE;
        end
      end else begin
        case (r_state)
          S_SETTLE: begin
            r_state        <= S_IDLE;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b1;
          end
          S_ISSUE: begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
          end
          S_WAIT: begin
            if (bus.op_done) begin
              r_state        <= S_IDLE;
              r_busy         <= 1'b0;
              r_result_valid <= 1'b1;
            end else if (r_cnt == CNT_LAST) begin
              r_state       <= S_IDLE;
              r_busy        <= 1'b0;
              r_timeout_err <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.mode         = r_mode;
  assign bus.op_start     = r_op_start;
  assign bus.busy         = r_busy;
  assign bus.result_valid = r_result_valid;
  assign bus.timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_calc_mode_controller.sv
// Directed-vector bench for calc_mode_controller: stepping, wrap, hold, cancel, serial done/timeout/abort, reset.
module tb_calc_mode_controller;

  logic clk = 1'b0;
  logic rst;
  int   n_vec   = 0;
  int   n_err   = 0;
  int   n_start = 0;
  int   n0;

  calc_mode_if #(.MODE_W(4)) bus();

  calc_mode_controller #(
    .NUM_MODES  (12),
    .MODE_W     (4),
    .SERIAL_MASK(12'h150),
    .TIMEOUT    (255)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.op_start === 1'b1) n_start++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  // Inputs seen at edge k are acted on at k+2, so the new mode is visible after the third edge.
  task automatic press(input logic i, input logic d, input logic [3:0] exp, input string tag);
    bus.inc_btn = i;
    bus.dec_btn = d;
    repeat (3) tick();
    chk(tag, 32'(bus.mode), 32'(exp));
    bus.inc_btn = 1'b0;
    bus.dec_btn = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    bus.inc_btn = 1'b0;
    bus.dec_btn = 1'b0;
    bus.sw      = 10'h000;
    bus.op_done = 1'b0;
    settle(3);
    chk("rst_mode", 32'(bus.mode), 0);
    chk("rst_busy", 32'(bus.busy), 1);
    chk("rst_rv", 32'(bus.result_valid), 0);
    chk("rst_start", 32'(bus.op_start), 0);
    chk("rst_tmo", 32'(bus.timeout_err), 0);

    rst = 1'b0;
    tick();
    chk("post_rst_rv", 32'(bus.result_valid), 1);
    chk("post_rst_busy", 32'(bus.busy), 0);
    settle(5);
    chk("idle_mode", 32'(bus.mode), 0);
    chk("idle_rv", 32'(bus.result_valid), 1);
    chk("idle_tmo", 32'(bus.timeout_err), 0);
    chk("idle_nostart", 32'(n_start), 0);

    for (int i = 1; i <= 12; i++) begin
      press(1'b1, 1'b0, 4'(i % 12), "inc_step");
      settle(4);
    end
    press(1'b0, 1'b1, 4'd11, "dec_wrap");
    settle(4);

    bus.inc_btn = 1'b1;
    repeat (100) tick();
    chk("inc_hold", 32'(bus.mode), 0);
    bus.inc_btn = 1'b0;
    settle(4);

    for (int i = 1; i <= 5; i++) begin
      press(1'b1, 1'b0, 4'(i), "inc_to_5");
      settle(4);
    end
    chk("m5_rv", 32'(bus.result_valid), 1);

    bus.inc_btn = 1'b1;
    bus.dec_btn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("both_busy", 32'(bus.busy), 0);
    end
    chk("both_mode", 32'(bus.mode), 5);
    bus.inc_btn = 1'b0;
    bus.dec_btn = 1'b0;
    settle(4);

    n0 = n_start;
    press(1'b0, 1'b1, 4'd4, "dec_to_4");
    chk("m4_start", 32'(bus.op_start), 1);
    chk("m4_busy", 32'(bus.busy), 1);
    chk("m4_rv", 32'(bus.result_valid), 0);
    tick();
    chk("m4_start_off", 32'(bus.op_start), 0);
    chk("m4_wait_busy", 32'(bus.busy), 1);
    settle(8);
    chk("m4_pre_rv", 32'(bus.result_valid), 0);
    chk("m4_pre_busy", 32'(bus.busy), 1);
    bus.op_done = 1'b1;
    tick();
    bus.op_done = 1'b0;
    chk("m4_done_rv", 32'(bus.result_valid), 1);
    chk("m4_done_busy", 32'(bus.busy), 0);
    tick();
    chk("m4_after_busy", 32'(bus.busy), 0);
    chk("m4_one_start", 32'(n_start - n0), 1);

    press(1'b1, 1'b0, 4'd5, "inc_to_5b");
    settle(4);
    press(1'b1, 1'b0, 4'd6, "inc_to_6");
    chk("m6_start", 32'(bus.op_start), 1);
    settle(255);
    chk("m6_wait_busy", 32'(bus.busy), 1);
    chk("m6_wait_tmo", 32'(bus.timeout_err), 0);
    tick();
    chk("m6_tmo", 32'(bus.timeout_err), 1);
    chk("m6_tmo_rv", 32'(bus.result_valid), 0);
    chk("m6_tmo_busy", 32'(bus.busy), 0);
    settle(3);
    chk("m6_tmo_sticky", 32'(bus.timeout_err), 1);
    bus.sw = 10'h001;
    settle(3);
    chk("sw_tmo_clr", 32'(bus.timeout_err), 0);
    chk("sw_start", 32'(bus.op_start), 1);
    chk("sw_mode", 32'(bus.mode), 6);
    chk("sw_busy", 32'(bus.busy), 1);
    settle(2);

    press(1'b1, 1'b0, 4'd7, "inc_to_7");
    settle(4);
    press(1'b1, 1'b0, 4'd8, "inc_to_8");
    chk("m8_start", 32'(bus.op_start), 1);
    settle(2);
    chk("m8_wait_busy", 32'(bus.busy), 1);
    n0 = n_start;
    press(1'b0, 1'b1, 4'd7, "abort_dec");
    chk("abort_start", 32'(bus.op_start), 0);
    chk("abort_busy", 32'(bus.busy), 1);
    chk("abort_rv", 32'(bus.result_valid), 0);
    tick();
    chk("abort_idle_rv", 32'(bus.result_valid), 1);
    chk("abort_idle_busy", 32'(bus.busy), 0);
    bus.op_done = 1'b1;
    tick();
    bus.op_done = 1'b0;
    tick();
    chk("late_done_rv", 32'(bus.result_valid), 1);
    chk("late_done_busy", 32'(bus.busy), 0);
    chk("late_done_mode", 32'(bus.mode), 7);
    chk("abort_nostart", 32'(n_start - n0), 0);
    settle(2);

    press(1'b1, 1'b0, 4'd8, "inc_to_8b");
    settle(2);
    chk("pre_rst_busy", 32'(bus.busy), 1);
    n0 = n_start;
    rst = 1'b1;
    #1;
    chk("arst_mode", 32'(bus.mode), 0);
    chk("arst_busy", 32'(bus.busy), 1);
    chk("arst_rv", 32'(bus.result_valid), 0);
    chk("arst_start", 32'(bus.op_start), 0);
    chk("arst_tmo", 32'(bus.timeout_err), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("rel_rv", 32'(bus.result_valid), 1);
    chk("rel_mode", 32'(bus.mode), 0);
    chk("rel_busy", 32'(bus.busy), 0);
    settle(3);
    chk("rel_nostart", 32'(n_start - n0), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
